// File: rtl/sprite_pixel_writer_pkg.sv
// Shared graphics definitions: line-buffer entry layout, pixel attributes, line geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sprite_pixel_writer_pkg;

   localparam int LINE_WIDTH_DEF = 640;
   localparam int X_W            = 10;
   localparam int COLOR_W        = 8;
   localparam int DEPTH_W        = 2;
   localparam int MASK_W         = 4;
   localparam int ENTRY_W        = 16;

   // Line-buffer entry; reserved bits are always written as zero.
   typedef struct packed {
      logic [1:0]         rsvd;
      logic [MASK_W-1:0]  mask;
      logic [DEPTH_W-1:0] depth;
      logic [COLOR_W-1:0] color;
   } entry_t;

   // Attributes of one sprite pixel carried from accept into the resolve stage.
   typedef struct packed {
      logic [X_W-1:0]     x;
      logic [COLOR_W-1:0] color;
      logic [DEPTH_W-1:0] depth;
      logic [MASK_W-1:0]  mask;
      logic               last;
   } pix_attr_t;

endpackage

// File: rtl/sprite_pixel_writer_if.sv
// Sprite pixel stream: valid/ready handshake plus pixel attributes.
// Latency: n/a (wires only).
// Backpressure: producer holds a pixel until pix_valid && pix_ready.
interface sprite_pixel_writer_if;
   import sprite_pixel_writer_pkg::*;

   logic               pix_valid;
   logic               pix_ready;
   logic [X_W-1:0]     pix_x;
   logic [COLOR_W-1:0] pix_color;
   logic [DEPTH_W-1:0] pix_depth;
   logic [MASK_W-1:0]  pix_coll_mask;
   logic               pix_last;

   modport master (
      output pix_valid, pix_x, pix_color, pix_depth, pix_coll_mask, pix_last,
      input  pix_ready
   );

   modport slave (
      input  pix_valid, pix_x, pix_color, pix_depth, pix_coll_mask, pix_last,
      output pix_ready
   );

endinterface

// File: rtl/sprite_pixel_writer.sv
// Merges sprite pixels into the line buffer (read-modify-write) and tracks collisions.
// Latency: read issued in accept cycle, write in the next cycle; line_done one cycle after that.
// Backpressure: ready every cycle except during rst or line_start; no bubbles.
module sprite_pixel_writer
   import sprite_pixel_writer_pkg::*;
#(
   parameter int LINE_WIDTH = LINE_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 line_start,
   sprite_pixel_writer_if.slave pix,
   output logic [X_W-1:0]       lb_rd_idx,
   input  logic [ENTRY_W-1:0]   lb_rd_data,
   output logic [X_W-1:0]       lb_wr_idx,
   output logic [ENTRY_W-1:0]   lb_wr_data,
   output logic                 lb_wr_en,
   output logic [MASK_W-1:0]    collision,
   output logic                 line_done,
   output logic                 busy
);

   localparam logic [X_W:0] LINE_LIMIT = (X_W+1)'(LINE_WIDTH);

   // Opaque pixel over an existing entry: the first opaque color/depth owns the
   // slot, later sprites only add their collision mask bits.
   function automatic entry_t merge_entry(input entry_t e, input pix_attr_t p);
      entry_t r;
      r.rsvd = '0;
      r.mask = e.mask | p.mask;
      if (e.color == '0) begin
         r.color = p.color;
         r.depth = p.depth;
      end else begin
         r.color = e.color;
         r.depth = e.depth;
      end
      return r;
   endfunction

   logic      accept;
   logic      s1_vld;
   pix_attr_t s1;
   logic      fwd_vld;
   entry_t    fwd_entry;
   entry_t    cur_entry;
   entry_t    new_entry;
   logic      s1_in_range;
   logic      wr_fire;

   assign pix.pix_ready = !rst && !line_start;
   assign accept        = pix.pix_valid && pix.pix_ready;
   assign lb_rd_idx     = accept ? pix.pix_x : '0;

   // The line buffer cannot yet show last cycle's write, so use the forwarded copy.
   assign cur_entry   = fwd_vld ? fwd_entry : entry_t'(lb_rd_data);
   assign new_entry   = merge_entry(cur_entry, s1);
   assign s1_in_range = {1'b0, s1.x} < LINE_LIMIT;
   assign wr_fire     = s1_vld && !rst && (s1.color != '0) && s1_in_range;

   assign lb_wr_en   = wr_fire;
   assign lb_wr_idx  = wr_fire ? s1.x : '0;
   assign lb_wr_data = wr_fire ? new_entry : '0;
   assign busy       = s1_vld && !rst;

   // Capture the accepted pixel's attributes for the resolve stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld <= 1'b0;
         s1     <= '0;
      end else begin
         s1_vld <= accept;
         if (accept) begin
            s1.x     <= pix.pix_x;
            s1.color <= pix.pix_color;
            s1.depth <= pix.pix_depth;
            s1.mask  <= pix.pix_coll_mask;
            s1.last  <= pix.pix_last;
         end
      end
   end

   // Remember this cycle's write when the pixel just accepted reads the same slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         fwd_vld   <= 1'b0;
         fwd_entry <= '0;
      end else begin
         fwd_vld <= wr_fire && accept && (pix.pix_x == s1.x);
         if (wr_fire && accept && (pix.pix_x == s1.x)) begin
            fwd_entry <= new_entry;
         end
      end
   end

   // Sticky collision bits for the current line.
   always_ff @(posedge clk) begin
      if (rst || line_start) begin
         collision <= '0;
      end else if (wr_fire) begin
         collision <= collision | (cur_entry.mask & s1.mask);
      end
   end

   // End-of-line pulse once the last pixel resolves, unless the line was aborted.
   always_ff @(posedge clk) begin
      if (rst) begin
         line_done <= 1'b0;
      end else begin
         line_done <= s1_vld && s1.last && !line_start;
      end
   end

endmodule

// File: tb/tb_sprite_pixel_writer.sv
// Randomized scoreboard bench for sprite_pixel_writer with an array-based line model.
// Latency: expected writes at accept+1, line_done at accept+2.
// Backpressure: pix_ready expected low only during rst or line_start.
module tb_sprite_pixel_writer;

   localparam int LW = 640;

   typedef struct {
      int          cyc;
      logic [9:0]  idx;
      logic [15:0] data;
   } wr_t;

   typedef struct {
      logic [9:0] x;
      logic [7:0] c;
      logic [1:0] d;
      logic [3:0] m;
      logic       l;
   } pix_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        line_start;
   logic [9:0]  lb_rd_idx;
   logic [15:0] lb_rd_data;
   logic [9:0]  lb_wr_idx;
   logic [15:0] lb_wr_data;
   logic        lb_wr_en;
   logic [3:0]  collision;
   logic        line_done;
   logic        busy;
   logic        lb_init;

   sprite_pixel_writer_if pix_if();

   sprite_pixel_writer dut (
      .clk        (clk),
      .rst        (rst),
      .line_start (line_start),
      .pix        (pix_if),
      .lb_rd_idx  (lb_rd_idx),
      .lb_rd_data (lb_rd_data),
      .lb_wr_idx  (lb_wr_idx),
      .lb_wr_data (lb_wr_data),
      .lb_wr_en   (lb_wr_en),
      .collision  (collision),
      .line_done  (line_done),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Line buffer attached to the DUT: one-cycle read, read-before-write.
   logic [15:0] lb_mem [0:1023];
   always @(posedge clk) begin
      if (lb_init) begin
         for (int i = 0; i < 1024; i++) lb_mem[i] <= 16'h0;
         lb_rd_data <= 16'h0;
      end else begin
         lb_rd_data <= lb_mem[lb_rd_idx];
         if (lb_wr_en) lb_mem[lb_wr_idx] <= lb_wr_data;
      end
   end

   // Reference state
   logic [15:0] ref_mem [0:1023];
   logic [3:0]  ref_coll;
   wr_t         exp_wr[$];
   int          exp_done[$];
   pix_t        pend;
   logic        have_pend;
   logic [9:0]  last_wr_idx;
   logic [15:0] last_wr_data;
   int          n_chk  = 0;
   int          n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Sequential model: one pixel merged into the line at a time.
   task automatic resolve(input pix_t p, input logic ls);
      logic [15:0] old;
      logic [15:0] nw;
      if (p.c != 8'h0 && int'(p.x) < LW) begin
         old = ref_mem[p.x];
         nw  = 16'h0;
         nw[13:10] = old[13:10] | p.m;
         if (old[7:0] == 8'h0) begin
            nw[7:0] = p.c;
            nw[9:8] = p.d;
         end else begin
            nw[7:0] = old[7:0];
            nw[9:8] = old[9:8];
         end
         ref_coll = ref_coll | (old[13:10] & p.m);
         ref_mem[p.x] = nw;
         exp_wr.push_back('{cyc, p.x, nw});
      end
      if (p.l && !ls) exp_done.push_back(cyc + 1);
   endtask

   // One clock of stimulus; the pixel accepted last cycle resolves in this one.
   task automatic step(input logic v, input logic [9:0] x, input logic [7:0] c,
                       input logic [1:0] d, input logic [3:0] m, input logic l,
                       input logic ls, input logic r);
      pix_if.pix_valid     = v;
      pix_if.pix_x         = x;
      pix_if.pix_color     = c;
      pix_if.pix_depth     = d;
      pix_if.pix_coll_mask = m;
      pix_if.pix_last      = l;
      line_start           = ls;
      rst                  = r;
      if (have_pend && !r) resolve(pend, ls);
      if (ls || r) ref_coll = 4'h0;
      #1;
      chk("pix_ready", 32'(pix_if.pix_ready), 32'(!(ls || r)));
      chk("lb_rd_idx", 32'(lb_rd_idx), (v && !ls && !r) ? 32'(x) : 32'h0);
      have_pend = v && !ls && !r;
      pend = '{x, c, d, m, l};
      @(posedge clk);
      #1;
      chk("collision", 32'(collision), 32'(ref_coll));
      chk("busy", 32'(busy), 32'(have_pend));
   endtask

   task automatic idle();
      step(1'b0, 10'd0, 8'h0, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic run_monitor();
      wr_t w;
      int  dc;
      forever begin
         @(negedge clk);
         while (exp_wr.size() > 0 && exp_wr[0].cyc < cyc) begin
            w = exp_wr.pop_front();
            chk("missing_write", 32'(lb_wr_en), 32'h1);
         end
         if (lb_wr_en) begin
            if (exp_wr.size() > 0 && exp_wr[0].cyc == cyc) begin
               w = exp_wr.pop_front();
               chk("wr_idx", 32'(lb_wr_idx), 32'(w.idx));
               chk("wr_data", 32'(lb_wr_data), 32'(w.data));
            end else begin
               chk("unexpected_write", 32'(lb_wr_en), 32'h0);
            end
            last_wr_idx  = lb_wr_idx;
            last_wr_data = lb_wr_data;
         end
         while (exp_done.size() > 0 && exp_done[0] < cyc) begin
            dc = exp_done.pop_front();
            chk("missing_line_done", 32'(line_done), 32'h1);
         end
         if (line_done) begin
            if (exp_done.size() > 0 && exp_done[0] == cyc) begin
               dc = exp_done.pop_front();
               chk("line_done", 32'(line_done), 32'h1);
            end else begin
               chk("unexpected_line_done", 32'(line_done), 32'h0);
            end
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n;
      int          rr;
      int          bad;
      logic [9:0]  rx;
      logic [7:0]  rc;

      for (int i = 0; i < 1024; i++) ref_mem[i] = 16'h0;
      ref_coll     = 4'h0;
      have_pend    = 1'b0;
      pend         = '{10'd0, 8'h0, 2'd0, 4'h0, 1'b0};
      last_wr_idx  = 10'd0;
      last_wr_data = 16'h0;
      lb_init      = 1'b1;
      rst          = 1'b1;
      line_start   = 1'b0;
      pix_if.pix_valid     = 1'b0;
      pix_if.pix_x         = 10'd0;
      pix_if.pix_color     = 8'h0;
      pix_if.pix_depth     = 2'd0;
      pix_if.pix_coll_mask = 4'h0;
      pix_if.pix_last      = 1'b0;
      fork
         run_monitor();
      join_none

      // Reset values
      @(posedge clk);
      #1;
      lb_init = 1'b0;
      step(1'b1, 10'd9, 8'h44, 2'd1, 4'h1, 1'b0, 1'b0, 1'b1);
      step(1'b0, 10'd0, 8'h0, 2'd0, 4'h0, 1'b0, 1'b0, 1'b1);
      chk("rst_wr_en", 32'(lb_wr_en), 32'h0);
      chk("rst_wr_idx", 32'(lb_wr_idx), 32'h0);
      chk("rst_wr_data", 32'(lb_wr_data), 32'h0);
      chk("rst_line_done", 32'(line_done), 32'h0);

      // Single opaque pixel on an empty line
      step(1'b0, 10'd0, 8'h0, 2'd0, 4'h0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 10'd5, 8'h12, 2'd2, 4'b0001, 1'b0, 1'b0, 1'b0);
      idle();
      chk("first_wr_idx", 32'(last_wr_idx), 32'd5);
      chk("first_wr_data", 32'(last_wr_data), 32'h0612);
      chk("first_collision", 32'(collision), 32'h0);

      // Back-to-back same slot: forwarded merge
      step(1'b1, 10'd7, 8'h20, 2'd1, 4'b0011, 1'b0, 1'b0, 1'b0);
      step(1'b1, 10'd7, 8'h30, 2'd3, 4'b0110, 1'b0, 1'b0, 1'b0);
      idle();
      chk("fwd_wr_data", 32'(last_wr_data), 32'h1D20);
      chk("fwd_collision", 32'(collision), 32'b0010);

      // Out-of-range and transparent pixels leave everything alone
      step(1'b1, 10'd640, 8'h77, 2'd0, 4'hF, 1'b0, 1'b0, 1'b0);
      step(1'b1, 10'd3, 8'h00, 2'd0, 4'hF, 1'b0, 1'b0, 1'b0);
      idle();
      idle();
      chk("discard_collision", 32'(collision), 32'b0010);

      // Collision then line_start clears it; a last pixel aborted by line_start
      step(1'b0, 10'd0, 8'h0, 2'd0, 4'h0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 10'd100, 8'h5A, 2'd0, 4'b0100, 1'b0, 1'b0, 1'b0);
      step(1'b1, 10'd100, 8'h6B, 2'd1, 4'b0100, 1'b0, 1'b0, 1'b0);
      idle();
      chk("coll_set", 32'(collision), 32'b0100);
      step(1'b1, 10'd200, 8'h11, 2'd0, 4'b0000, 1'b1, 1'b0, 1'b0);
      step(1'b0, 10'd0, 8'h0, 2'd0, 4'h0, 1'b0, 1'b1, 1'b0);
      chk("coll_cleared", 32'(collision), 32'h0);
      idle();

      // Reset with a pixel in flight drops it
      step(1'b1, 10'd100, 8'h01, 2'd0, 4'b0100, 1'b0, 1'b0, 1'b0);
      idle();
      chk("pre_rst_coll", 32'(collision), 32'b0100);
      step(1'b1, 10'd50, 8'h55, 2'd2, 4'b1000, 1'b0, 1'b0, 1'b0);
      step(1'b0, 10'd0, 8'h0, 2'd0, 4'h0, 1'b0, 1'b0, 1'b1);
      chk("post_rst_coll", 32'(collision), 32'h0);
      chk("post_rst_done", 32'(line_done), 32'h0);
      chk("post_rst_wr_en", 32'(lb_wr_en), 32'h0);
      chk("post_rst_rd_idx", 32'(lb_rd_idx), 32'h0);
      step(1'b1, 10'd51, 8'h56, 2'd1, 4'b0001, 1'b0, 1'b0, 1'b0);
      idle();

      // Full line of consecutive opaque pixels
      step(1'b0, 10'd0, 8'h0, 2'd0, 4'h0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < LW; i++) begin
         rc = 8'($urandom_range(1, 255));
         step(1'b1, 10'(i), rc, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
              (i == LW - 1), 1'b0, 1'b0);
      end
      idle();
      idle();
      idle();

      // Random lines with occasional aborts and resets
      for (int ln = 0; ln < 6; ln++) begin
         step(1'b0, 10'd0, 8'h0, 2'd0, 4'h0, 1'b0, 1'b1, 1'b0);
         n = $urandom_range(50, 250);
         for (int i = 0; i < n; i++) begin
            rr = $urandom_range(0, 99);
            if (rr < 2) begin
               step(1'b0, 10'd0, 8'h0, 2'd0, 4'h0, 1'b0, 1'b1, 1'b0);
            end else if (rr == 2 && ln > 2) begin
               step(1'b0, 10'd0, 8'h0, 2'd0, 4'h0, 1'b0, 1'b0, 1'b1);
            end else if (rr < 25) begin
               idle();
            end else begin
               rx = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 15))
                                                : 10'($urandom_range(0, 1023));
               rc = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
               step(1'b1, rx, rc, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                    1'b0, 1'b0, 1'b0);
            end
         end
         rx = 10'($urandom_range(0, 700));
         step(1'b1, rx, 8'($urandom_range(0, 255)), 2'd0, 4'($urandom_range(0, 15)),
              1'b1, 1'b0, 1'b0);
         idle();
         idle();
         idle();
      end

      // Drain and final consistency
      for (int i = 0; i < 5; i++) idle();
      @(negedge clk);
      #1;
      chk("pending_writes", 32'(exp_wr.size()), 32'h0);
      chk("pending_line_done", 32'(exp_done.size()), 32'h0);
      bad = 0;
      for (int i = 0; i < 1024; i++) if (lb_mem[i] !== ref_mem[i]) bad++;
      chk("line_buffer_contents", 32'(bad), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sprite_pixel_writer.md
SPRITE_PIXEL_WRITER -- requirements
Module: sprite_pixel_writer

Interface
REQ-001 Parameter LINE_WIDTH, default 640, number of visible pixel slots per line; pixels at x >= LINE_WIDTH are discarded.
REQ-002 clk  input  1  single clock; all logic rising-edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 line_start  input  1  one-cycle pulse; begins a new line and clears collision state.
REQ-005 pix_valid  input  1  pixel offered.
REQ-006 pix_ready  output  1  pixel accepted when pix_valid && pix_ready.
REQ-007 pix_x  input  10  line-buffer index of the pixel.
REQ-008 pix_color  input  8  palette index; 0 = transparent.
REQ-009 pix_depth  input  2  sprite z-depth.
REQ-010 pix_coll_mask  input  4  sprite collision mask.
REQ-011 pix_last  input  1  marks the final pixel of the line's sprite work.
REQ-012 lb_rd_idx  output  10  line-buffer read index; data returns one cycle later.
REQ-013 lb_rd_data  input  16  line-buffer read data.
REQ-014 lb_wr_idx / lb_wr_data / lb_wr_en  output  10 / 16 / 1  line-buffer write port.
REQ-015 collision  output  4  sticky OR of detected collision bits.
REQ-016 line_done  output  1  one-cycle pulse after the pix_last pixel is resolved.
REQ-017 busy  output  1  high while any accepted pixel is unresolved.

Function
REQ-018 Entry format: [7:0] color, [9:8] depth, [13:10] collision mask, [15:14] always written 0.
REQ-019 pix_ready = !rst && !line_start; one pixel per cycle sustained, no bubbles.
REQ-020 Stage 0 (accept cycle N): lb_rd_idx = pix_x combinationally; attributes registered into stage 1.
REQ-021 Stage 1 (cycle N+1): existing entry E = lb_rd_data, or the forwarded entry when REQ-024 applies; decision and write occur in this same cycle.
REQ-022 Transparent pixel (color 0) or x >= LINE_WIDTH: no write, no collision contribution.
REQ-023 Opaque in-range pixel: lb_wr_en=1, lb_wr_idx=x; if E.color==0 write {new color, new depth}, else keep {E.color, E.depth}; mask field = E.mask | new mask.
REQ-024 Forwarding: if the stage-1 write in cycle N+1 targets the idx read in cycle N+1, the next stage-1 uses the written entry instead of lb_rd_data.
REQ-025 Collision: collision |= E.mask & new mask for every opaque in-range pixel; cleared only by line_start or rst.
REQ-026 line_done pulses in the cycle after the stage-1 cycle of the pix_last pixel, including when that pixel is discarded.
REQ-027 lb_rd_idx outputs 0 when no pixel is accepted.
REQ-028 line_start mid-line: stage-1 pixel still completes its write; forward state and collision cleared; no line_done for the aborted line.
REQ-029 No state spans lines except via the line buffer.

Reset
REQ-030 On rst: pix_ready=0, lb_wr_en=0, lb_wr_idx=0, lb_wr_data=0, lb_rd_idx=0, collision=0, line_done=0, busy=0, stage-1 valid and forward valid cleared.
REQ-031 rst mid-operation drops in-flight pixels without writing; first acceptance possible the cycle after rst deasserts.

Structure
REQ-032 Entry field positions, widths and LINE_WIDTH default live in the shared graphics package, shared with the line buffer and composer.
REQ-033 Single module; no sub-module; entry merge is an internal function.

Verification
REQ-034 Empty line (all zero), opaque pixel x=5 color 0x12 depth 2 mask 0001 -> N+1 write idx 5 data 0x0612, collision 0.
REQ-035 Back-to-back x=7 color 0x20 mask 0011 then x=7 color 0x30 mask 0110 -> second write idx 7 data color 0x20, mask 0111, collision=0010 (forwarding).
REQ-036 Pixel x=640 and pixel color 0 at x=3 -> no lb_wr_en; collision unchanged.
REQ-037 640 consecutive opaque pixels, last with pix_last -> 640 writes on consecutive cycles, pix_ready always high, single line_done one cycle after last write.
REQ-038 collision=0100 then line_start -> collision=0 next cycle; pix_ready low during the pulse.
REQ-039 rst asserted while pixel in stage 1 -> no write that cycle, all outputs at reset values next cycle.
